// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: scans SLICE bits per clock from the MSB, unsigned or signed,
// with 4-bit-family cascade inputs for ties. Optional macro SEQ_MAG_CMP_EARLY_EXIT_EN.
module seq_mag_comparator #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             in_agb,
    input  logic             in_alb,
    input  logic             in_aeb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_agb,
    output logic             out_alb,
    output logic             out_aeb
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic [2:0]         r_cas;
    logic [KW-1:0]      r_k;
    logic               r_decided;
    logic               r_agb;
    logic               r_alb;
    logic               r_aeb;

    logic [SLICE-1:0]   w_flip;
    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic               w_gt;
    logic               w_lt;
    logic               w_last;

    // Operands shift left each compare cycle, so the current slice is always the top SLICE bits.
    // Flipping the sign bit of the MSB slice maps two's-complement order onto unsigned order.
    assign w_flip    = (r_signed && (r_k == '0)) ? (SLICE'(1) << (SLICE - 1)) : '0;
    assign w_a_slice = r_a[WIDTH-1 -: SLICE] ^ w_flip;
    assign w_b_slice = r_b[WIDTH-1 -: SLICE] ^ w_flip;
    assign w_gt      = (w_a_slice > w_b_slice);
    assign w_lt      = (w_a_slice < w_b_slice);
    assign w_last    = (r_k == KW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = COMPARE;
                end
            end
            COMPARE: begin
`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
                if (w_last || w_gt || w_lt) begin
                    w_state_next = DONE;
                end
`else
                if (w_last) begin
                    w_state_next = DONE;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_cas     <= 3'b000;
            r_k       <= '0;
            r_decided <= 1'b0;
            r_agb     <= 1'b0;
            r_alb     <= 1'b0;
            r_aeb     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_signed  <= is_signed;
                        r_cas     <= {in_agb, in_alb, in_aeb};
                        r_k       <= '0;
                        r_decided <= 1'b0;
                        r_agb     <= 1'b0;
                        r_alb     <= 1'b0;
                        r_aeb     <= 1'b0;
                    end
                end
                COMPARE: begin
                    r_a <= r_a << SLICE;
                    r_b <= r_b << SLICE;
                    r_k <= r_k + KW'(1);
                    // The first differing slice wins; later slices are scanned but ignored.
                    if (!r_decided) begin
                        if (w_gt) begin
                            r_agb     <= 1'b1;
                            r_decided <= 1'b1;
                        end else if (w_lt) begin
                            r_alb     <= 1'b1;
                            r_decided <= 1'b1;
                        end else if (w_last) begin
                            {r_agb, r_alb, r_aeb} <= r_cas;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_agb = r_agb;
    assign out_alb = r_alb;
    assign out_aeb = r_aeb;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed and random checks of seq_mag_comparator at WIDTH=16, SLICE=4, both build variants.
module tb_seq_mag_comparator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        is_signed;
    logic        in_agb;
    logic        in_alb;
    logic        in_aeb;
    logic        out_valid;
    logic        out_ready;
    logic        out_agb;
    logic        out_alb;
    logic        out_aeb;

    int checks = 0;
    int errors = 0;

    seq_mag_comparator #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed),
        .in_agb(in_agb), .in_alb(in_alb), .in_aeb(in_aeb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_agb(out_agb), .out_alb(out_alb), .out_aeb(out_aeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_cmp(input logic [15:0] ra, input logic [15:0] rb,
                                           input logic rs, input logic [2:0] rc);
        if (ra == rb) return rc;
        if (rs) return ($signed(ra) > $signed(rb)) ? 3'b100 : 3'b010;
        return (ra > rb) ? 3'b100 : 3'b010;
    endfunction

    function automatic int ref_lat(input logic [15:0] ra, input logic [15:0] rb);
`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
        for (int d = 0; d < 4; d++) begin
            if (ra[15-4*d -: 4] != rb[15-4*d -: 4]) return d + 1;
        end
        return 4;
`else
        return 4;
`endif
    endfunction

    // Drives one request, waits (bounded) for the result, stalls, then completes the handshake.
    // lat = -1 signals that no result appeared.
    task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                           input logic [2:0] tc, input int stall,
                           output logic [2:0] res, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; is_signed = ts; {in_agb, in_alb, in_aeb} = tc;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        if (out_valid !== 1'b1) begin
            lat = -1;
            res = 3'bxxx;
            $display("txn a=%h b=%h s=%0d cas=%b : no result", ta, tb_v, ts, tc);
            return;
        end
        res = {out_agb, out_alb, out_aeb};
        repeat (stall) @(posedge clk);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        $display("txn a=%h b=%h s=%0d cas=%b res=%b lat=%0d", ta, tb_v, ts, tc, res, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; is_signed = 1'b0; {in_agb, in_alb, in_aeb} = 3'b000;
        #2;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({in_ready, out_valid, out_agb, out_alb, out_aeb} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_outputs phase=%0d got=%b want=10000", p,
                         {in_ready, out_valid, out_agb, out_alb, out_aeb});
            end
            repeat (2) @(posedge clk);
            @(negedge clk) rst_n = 1'b1;
            #1;
        end
    endtask

    task automatic test_unsigned_lsb();
        logic [2:0] res; int lat;
        run_txn(16'h1234, 16'h1235, 1'b0, 3'b000, 0, res, lat);
        checks++;
        if (res !== 3'b010) begin
            errors++; $display("FAIL lsb_result got=%b want=010", res);
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL lsb_latency got=%0d want=4", lat);
        end
    endtask

    task automatic test_mode_swap();
        logic [2:0] res; int lat; int want_lat;
`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
        want_lat = 1;
`else
        want_lat = 4;
`endif
        for (int s = 0; s < 2; s++) begin
            run_txn(16'h8000, 16'h0001, s[0], 3'b000, 1, res, lat);
            checks++;
            if (res !== (s == 0 ? 3'b100 : 3'b010)) begin
                errors++; $display("FAIL mode_swap_result signed=%0d got=%b want=%b", s, res,
                                   (s == 0 ? 3'b100 : 3'b010));
            end
            checks++;
            if (lat !== want_lat) begin
                errors++; $display("FAIL mode_swap_latency signed=%0d got=%0d want=%0d", s, lat, want_lat);
            end
        end
    endtask

    task automatic test_cascade();
        logic [2:0] res; int lat;
        logic [2:0] cas_tab [4] = '{3'b001, 3'b100, 3'b010, 3'b110};
        for (int i = 0; i < 4; i++) begin
            run_txn(16'hBEEF, 16'hBEEF, i[0], cas_tab[i], 0, res, lat);
            checks++;
            if (res !== cas_tab[i]) begin
                errors++; $display("FAIL cascade_result cas=%b got=%b want=%b", cas_tab[i], res, cas_tab[i]);
            end
            checks++;
            if (lat !== 4) begin
                errors++; $display("FAIL cascade_latency cas=%b got=%0d want=4", cas_tab[i], lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        a = 16'hF000; b = 16'h0000; is_signed = 1'b0; {in_agb, in_alb, in_aeb} = 3'b001;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_timeout got=out_valid 0 want=1");
            return;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            // A stray request while the result is held must not be taken.
            in_valid = (c == 1 || c == 2);
            a = 16'h0000; b = 16'hFFFF;
            checks++;
            if ({out_valid, out_agb, out_alb, out_aeb, in_ready} !== 5'b11000) begin
                errors++; $display("FAIL bp_hold cycle=%0d got=%b want=11000", c,
                                   {out_valid, out_agb, out_alb, out_aeb, in_ready});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release got={valid,ready}=%b want=01", {out_valid, in_ready});
        end
        $display("txn a=f000 b=0000 s=0 cas=001 held 5 cycles lat=%0d", lat);
    endtask

    task automatic test_reset_mid();
        logic [2:0] res; int lat; int seen;
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; is_signed = 1'b0; {in_agb, in_alb, in_aeb} = 3'b001;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_agb, out_alb, out_aeb} !== 5'b10000) begin
            errors++; $display("FAIL reset_mid_outputs got=%b want=10000",
                               {in_ready, out_valid, out_agb, out_alb, out_aeb});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL reset_mid_no_result got=%0d valid cycles want=0", seen);
        end
        $display("txn a=0001 b=0002 aborted by reset");
        run_txn(16'h0001, 16'h0002, 1'b0, 3'b001, 0, res, lat);
        checks++;
        if (res !== 3'b010) begin
            errors++; $display("FAIL reset_mid_fresh_result got=%b want=010", res);
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL reset_mid_fresh_latency got=%0d want=4", lat);
        end
    endtask

    task automatic test_random(input int count);
        logic [2:0] res; int lat;
        logic [15:0] ra, rb; logic rs; logic [2:0] rc;
        for (int i = 0; i < count; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            // Bias towards shared upper slices and exact ties.
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = {ra[15:4], rb[3:0]};
                2: rb = {ra[15:8], rb[7:0]};
                default: ;
            endcase
            rs = 1'($urandom);
            rc = 3'($urandom);
            run_txn(ra, rb, rs, rc, $urandom_range(0, 2), res, lat);
            checks++;
            if (res !== ref_cmp(ra, rb, rs, rc)) begin
                errors++; $display("FAIL random_result a=%h b=%h s=%0d cas=%b got=%b want=%b",
                                   ra, rb, rs, rc, res, ref_cmp(ra, rb, rs, rc));
            end
            checks++;
            if (lat !== ref_lat(ra, rb)) begin
                errors++; $display("FAIL random_latency a=%h b=%h got=%0d want=%0d",
                                   ra, rb, lat, ref_lat(ra, rb));
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_lsb();
        test_mode_swap();
        test_cascade();
        test_backpressure();
        test_reset_mid();
        test_random(1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
